rf_fft_cfg_issuer: RTL and testbench
====================================

Name: rf_fft_cfg_issuer

Overview:
- Instruction-side driver for the FFT register file.
- Accepts one FFT job request per handshake and packs it into the RF resource instruction stream: DSU/REP for the bulk write/read ports (2, 3) and FFT config for the word AGU ports (0, 1).
- After the last instruction it pulses the RF activate lines for one cycle.
- Sits between the sequencer/controller and the RF's instr_en/instr/activate inputs.

Parameters:
- RESOURCE_INSTR_WIDTH, 27, instruction width; opcode in [26:24], payload in [23:0].
- INSTR_OPCODE_BITWIDTH, 3, opcode field width.
- AGU_BITWIDTH, 16, width of DSU init address.
- RF_DEPTH, 128, RF words; maximum legal n_points.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  job request valid.
- req_ready  out  1  high when IDLE.
- req_n_points  in  12  FFT size.
- req_radix  in  2  radix field.
- req_mode  in  1  FFT mode field.
- req_n_bu  in  1  butterfly count field.
- req_fft_delay  in  6  FFT delay field.
- req_w_base  in  16  bulk write (port 2) initial address.
- req_r_base  in  16  bulk read (port 3) initial address.
- req_iter  in  6  bulk REP iterations.
- req_step  in  6  bulk REP step.
- req_bdelay  in  6  bulk REP delay.
- req_port_mask  in  4  bit p = configure/activate port p.
- hold  in  1  freeze issue.
- instr_en  out  1  instruction valid.
- instr  out  27  packed instruction.
- activate_0  out  4  RF slot-0 activate.
- activate_1  out  4  RF slot-1 activate.
- done  out  1  one-cycle pulse with activate.
- err  out  1  one-cycle pulse on rejected job.

Behaviour:
- Reset:
  - state IDLE.
  - instr_en=0, instr=0, activate_0=0, activate_1=0, done=0, err=0; all outputs registered.
  - req_ready=1 after reset.
  - Reset mid-job aborts immediately, with no further instructions or activate.
- Accept: req_valid & req_ready at edge T; all req_* fields latched.
- Validation at accept:
  - n_points must be a power of two, 4 <= n_points <= RF_DEPTH.
  - port_mask must be nonzero.
  - If invalid: err=1 at T+1, no instructions issued, stay IDLE.
- Issue states, in order: DSU_W, REP_W, DSU_R, REP_R, FFT_W, FFT_R, ACT.
  - DSU_W, REP_W require mask[2]; DSU_R, REP_R require mask[3]; FFT_W requires mask[0]; FFT_R requires mask[1].
  - Disabled states are skipped with zero cycles; next state is computed through skip logic.
  - First instruction appears at T+1.
  - Each issue state holds instr_en=1 for exactly one cycle.
- Encodings:
  - DSU: opcode 6; [23]=0, [22:7]=base, [6:5]=port.
  - REP: opcode 0; [23:22]=port, [21:18]=0 (level 0), [17:12]=iter, [11:6]=step, [5:0]=bdelay.
  - FFT: opcode 4; [23:22]=port (0 or 1), [21:10]=n_points, [9:8]=radix, [7]=n_bu, [6]=mode, [5:0]=fft_delay.
  - When instr_en=0, instr is driven to 0.
- ACT (one cycle):
  - activate_0 = mask.
  - activate_1 = {2'b00, mask[1:0]}.
  - done=1.
  - Next state IDLE, so req_ready=1 the following cycle.
  - Back-to-back jobs: minimum gap is one IDLE cycle.
- Full mask: 6 instruction cycles plus 1 ACT cycle, i.e. ACT at T+7.
- hold=1:
  - State frozen.
  - instr_en, activate_*, done forced 0 that cycle.
  - The pending instruction or activate is re-issued after hold drops; nothing is lost or duplicated.
  - hold in IDLE does not block accept.
- Requests while busy are not accepted (req_ready=0).

Decomposition:
- Shared package rf_fft_cfg_pkg holds:
  - opcode constants OP_REP=0, OP_FFT=4, OP_DSU=6.
  - dsu_t/rep_t/fft_t structs with pack functions, bit-identical to the RF's unpack layout.
  - state enum.
- Sub-module rf_fft_cfg_validate: combinational power-of-two and range check.

Test Plan:
- Full job: n_points=16, radix=2, mode=0, n_bu=1, fft_delay=3, w_base=0, r_base=8, iter=4, step=1, bdelay=0, mask=4'hF.
  - Expected instr sequence: 0x6000040, 0x0804040, 0x6000460, 0x0C04040, 0x4004283, 0x4404283.
  - Then activate_0=4'hF, activate_1=4'h3, done=1 at T+7.
- mask=4'b0011, same fields: only 0x4004283, 0x4404283 are issued; ACT at T+3 with activate_0=4'h3, activate_1=4'h3.
- n_points=12 (and separately 256, and mask=0): err pulse at T+1, zero instr_en, req_ready stays 1.
- hold=1 for 3 cycles during REP_R of the full job: REP_R is issued exactly once after release, and ACT is delayed by 3 cycles (T+10).
- rst_n low for one cycle during FFT_W: all outputs 0 immediately, no activate afterwards, req_ready=1 after release.
- Second req_valid held during a job: it is accepted only on the IDLE cycle after done, and its first instruction follows one cycle later.

Source files
------------

// File: rtl/rf_fft_cfg_pkg.sv
// Shared types and instruction packers for the FFT register-file configuration issuer.
// Packed layouts are bit-identical to the RF unpack side.
package rf_fft_cfg_pkg;

   localparam logic [2:0] OP_REP = 3'd0;
   localparam logic [2:0] OP_FFT = 3'd4;
   localparam logic [2:0] OP_DSU = 3'd6;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_DSU_W = 3'd1,
      S_REP_W = 3'd2,
      S_DSU_R = 3'd3,
      S_REP_R = 3'd4,
      S_FFT_W = 3'd5,
      S_FFT_R = 3'd6,
      S_ACT   = 3'd7
   } state_t;

   typedef struct packed {
      logic [15:0] base;
      logic [1:0]  port;
   } dsu_t;

   typedef struct packed {
      logic [1:0] port;
      logic [5:0] iter;
      logic [5:0] step;
      logic [5:0] bdelay;
   } rep_t;

   typedef struct packed {
      logic [1:0]  port;
      logic [11:0] n_points;
      logic [1:0]  radix;
      logic        n_bu;
      logic        mode;
      logic [5:0]  fft_delay;
   } fft_t;

   function automatic logic [26:0] pack_dsu(dsu_t d);
      return {OP_DSU, 1'b0, d.base, d.port, 5'b0};
   endfunction

   // Level field is always 0: this issuer only drives single-level REP.
   function automatic logic [26:0] pack_rep(rep_t r);
      return {OP_REP, r.port, 4'b0, r.iter, r.step, r.bdelay};
   endfunction

   function automatic logic [26:0] pack_fft(fft_t f);
      return {OP_FFT, f.port, f.n_points, f.radix, f.n_bu, f.mode, f.fft_delay};
   endfunction

   // First enabled issue state at or after s; ACT is always enabled.
   function automatic state_t skip_from(state_t s, logic [3:0] m);
      state_t r;
      r = S_ACT;
      if (s <= S_FFT_R && m[1]) r = S_FFT_R;
      if (s <= S_FFT_W && m[0]) r = S_FFT_W;
      if (s <= S_DSU_R && m[3]) r = S_DSU_R;
      if (s <= S_DSU_W && m[2]) r = S_DSU_W;
      return r;
   endfunction

endpackage

// File: rtl/rf_fft_cfg_issuer_validate.sv
// Combinational job check: n_points a power of two in [4, RF_DEPTH], nonzero port mask.
module rf_fft_cfg_validate
   import rf_fft_cfg_pkg::*;
#(
   parameter int RF_DEPTH = 128
) (
   input  logic [11:0] n_points,
   input  logic [3:0]  port_mask,
   output logic        ok
);

   localparam logic [11:0] MAX_N = 12'(RF_DEPTH);

   logic pow2;
   logic in_range;

   assign pow2     = (n_points != 12'd0) && ((n_points & (n_points - 12'd1)) == 12'd0);
   assign in_range = (n_points >= 12'd4) && (n_points <= MAX_N);
   assign ok       = pow2 && in_range && (port_mask != 4'd0);

endmodule

// File: rtl/rf_fft_cfg_issuer.sv
// Packs one FFT job into the RF instruction stream, then pulses the activate lines.
// state   | meaning
// IDLE    | ready for a job request
// DSU_W   | bulk write port 2 init address
// REP_W   | bulk write port 2 repetition
// DSU_R   | bulk read port 3 init address
// REP_R   | bulk read port 3 repetition
// FFT_W   | FFT config on word port 0
// FFT_R   | FFT config on word port 1
// ACT     | activate pulse and done
module rf_fft_cfg_issuer
   import rf_fft_cfg_pkg::*;
#(
   parameter int RESOURCE_INSTR_WIDTH  = 27,
   parameter int INSTR_OPCODE_BITWIDTH = 3,
   parameter int AGU_BITWIDTH          = 16,
   parameter int RF_DEPTH              = 128
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            req_valid,
   output logic                            req_ready,
   input  logic [11:0]                     req_n_points,
   input  logic [1:0]                      req_radix,
   input  logic                            req_mode,
   input  logic                            req_n_bu,
   input  logic [5:0]                      req_fft_delay,
   input  logic [AGU_BITWIDTH-1:0]         req_w_base,
   input  logic [AGU_BITWIDTH-1:0]         req_r_base,
   input  logic [5:0]                      req_iter,
   input  logic [5:0]                      req_step,
   input  logic [5:0]                      req_bdelay,
   input  logic [3:0]                      req_port_mask,
   input  logic                            hold,
   output logic                            instr_en,
   output logic [RESOURCE_INSTR_WIDTH-1:0] instr,
   output logic [3:0]                      activate_0,
   output logic [3:0]                      activate_1,
   output logic                            done,
   output logic                            err
);

   localparam int PAYLOAD_W = RESOURCE_INSTR_WIDTH - INSTR_OPCODE_BITWIDTH;

   state_t                            state;
   logic [11:0]                       n_points_q;
   logic [1:0]                        radix_q;
   logic                              mode_q;
   logic                              n_bu_q;
   logic [5:0]                        fft_delay_q;
   logic [AGU_BITWIDTH-1:0]           w_base_q;
   logic [AGU_BITWIDTH-1:0]           r_base_q;
   logic [5:0]                        iter_q;
   logic [5:0]                        step_q;
   logic [5:0]                        bdelay_q;
   logic [3:0]                        mask_q;
   logic                              err_pend;
   logic                              job_ok;
   logic [RESOURCE_INSTR_WIDTH-1:0]   issue_word;
   logic [INSTR_OPCODE_BITWIDTH-1:0]  op_q;
   logic [PAYLOAD_W-1:0]              pay_q;

   rf_fft_cfg_validate #(.RF_DEPTH(RF_DEPTH)) u_validate (
      .n_points  (req_n_points),
      .port_mask (req_port_mask),
      .ok        (job_ok)
   );

   assign req_ready = (state == S_IDLE);
   assign instr     = {op_q, pay_q};

   always_comb begin
      issue_word = '0;
      case (state)
         S_DSU_W: issue_word = pack_dsu(dsu_t'{base: w_base_q, port: 2'd2});
         S_REP_W: issue_word = pack_rep(rep_t'{port: 2'd2, iter: iter_q, step: step_q, bdelay: bdelay_q});
         S_DSU_R: issue_word = pack_dsu(dsu_t'{base: r_base_q, port: 2'd3});
         S_REP_R: issue_word = pack_rep(rep_t'{port: 2'd3, iter: iter_q, step: step_q, bdelay: bdelay_q});
         S_FFT_W: issue_word = pack_fft(fft_t'{port: 2'd0, n_points: n_points_q, radix: radix_q,
                                               n_bu: n_bu_q, mode: mode_q, fft_delay: fft_delay_q});
         S_FFT_R: issue_word = pack_fft(fft_t'{port: 2'd1, n_points: n_points_q, radix: radix_q,
                                               n_bu: n_bu_q, mode: mode_q, fft_delay: fft_delay_q});
         default: issue_word = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         n_points_q  <= '0;
         radix_q     <= '0;
         mode_q      <= 1'b0;
         n_bu_q      <= 1'b0;
         fft_delay_q <= '0;
         w_base_q    <= '0;
         r_base_q    <= '0;
         iter_q      <= '0;
         step_q      <= '0;
         bdelay_q    <= '0;
         mask_q      <= '0;
         err_pend    <= 1'b0;
         instr_en    <= 1'b0;
         op_q        <= '0;
         pay_q       <= '0;
         activate_0  <= '0;
         activate_1  <= '0;
         done        <= 1'b0;
         err         <= 1'b0;
      end else begin
         instr_en   <= 1'b0;
         op_q       <= '0;
         pay_q      <= '0;
         activate_0 <= '0;
         activate_1 <= '0;
         done       <= 1'b0;
         err        <= err_pend;
         err_pend   <= 1'b0;
         if (state == S_IDLE) begin
            if (req_valid) begin
               n_points_q  <= req_n_points;
               radix_q     <= req_radix;
               mode_q      <= req_mode;
               n_bu_q      <= req_n_bu;
               fft_delay_q <= req_fft_delay;
               w_base_q    <= req_w_base;
               r_base_q    <= req_r_base;
               iter_q      <= req_iter;
               step_q      <= req_step;
               bdelay_q    <= req_bdelay;
               mask_q      <= req_port_mask;
               if (job_ok) state <= skip_from(S_DSU_W, req_port_mask);
               else        err_pend <= 1'b1;
            end
         end else if (!hold) begin
            // Hold freezes the state so the pending word is re-issued afterwards.
            if (state == S_ACT) begin
               activate_0 <= mask_q;
               activate_1 <= {2'b00, mask_q[1:0]};
               done       <= 1'b1;
            end else begin
               instr_en <= 1'b1;
               op_q     <= issue_word[RESOURCE_INSTR_WIDTH-1 -: INSTR_OPCODE_BITWIDTH];
               pay_q    <= issue_word[PAYLOAD_W-1:0];
            end
            case (state)
               S_DSU_W: state <= S_REP_W;
               S_REP_W: state <= skip_from(S_DSU_R, mask_q);
               S_DSU_R: state <= S_REP_R;
               S_REP_R: state <= skip_from(S_FFT_W, mask_q);
               S_FFT_W: state <= skip_from(S_FFT_R, mask_q);
               S_FFT_R: state <= S_ACT;
               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_rf_fft_cfg_issuer.sv
// Self-checking bench for rf_fft_cfg_issuer: queue-based job model plus directed literal checks.
module tb_rf_fft_cfg_issuer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [11:0] req_n_points = '0;
   logic [1:0]  req_radix = '0;
   logic        req_mode = 1'b0;
   logic        req_n_bu = 1'b0;
   logic [5:0]  req_fft_delay = '0;
   logic [15:0] req_w_base = '0;
   logic [15:0] req_r_base = '0;
   logic [5:0]  req_iter = '0;
   logic [5:0]  req_step = '0;
   logic [5:0]  req_bdelay = '0;
   logic [3:0]  req_port_mask = '0;
   logic        hold = 1'b0;
   logic        instr_en;
   logic [26:0] instr;
   logic [3:0]  activate_0;
   logic [3:0]  activate_1;
   logic        done;
   logic        err;

   always #5 clk = ~clk;

   rf_fft_cfg_issuer dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_n_points(req_n_points), .req_radix(req_radix), .req_mode(req_mode),
      .req_n_bu(req_n_bu), .req_fft_delay(req_fft_delay), .req_w_base(req_w_base),
      .req_r_base(req_r_base), .req_iter(req_iter), .req_step(req_step),
      .req_bdelay(req_bdelay), .req_port_mask(req_port_mask), .hold(hold),
      .instr_en(instr_en), .instr(instr), .activate_0(activate_0),
      .activate_1(activate_1), .done(done), .err(err)
   );

   typedef struct {
      logic        en;
      logic [26:0] instr;
      logic [3:0]  a0;
      logic [3:0]  a1;
      logic        done;
   } word_t;

   word_t       q[$];
   int          cyc = 0;
   int          checks = 0;
   int          errors = 0;
   int          t_acc = 0;
   logic        exp_en = 1'b0;
   logic [26:0] exp_instr = '0;
   logic [3:0]  exp_a0 = '0;
   logic [3:0]  exp_a1 = '0;
   logic        exp_done = 1'b0;
   logic        exp_err = 1'b0;
   logic        exp_ready = 1'b1;
   logic        err_pipe = 1'b0;
   logic [26:0] log_instr[$];
   int          log_cyc[$];
   int          done_cyc = -1;
   int          err_cyc = -1;
   logic [3:0]  act0_seen = '0;
   logic [3:0]  act1_seen = '0;
   logic [26:0] full_seq [0:5] = '{27'h6000040, 27'h0804040, 27'h6000460,
                                  27'h0C04040, 27'h4004283, 27'h4404283};

   function automatic bit legal_size(int n);
      for (int k = 2; k <= 7; k++) if (n == (1 << k)) return 1'b1;
      return 1'b0;
   endfunction

   function automatic void push_word(logic en, int ins, logic [3:0] a0, logic [3:0] a1, logic d);
      word_t w;
      w.en = en; w.instr = ins[26:0]; w.a0 = a0; w.a1 = a1; w.done = d;
      q.push_back(w);
   endfunction

   // Expected output words of one legal job, built directly from the field layout.
   function automatic void push_job();
      int rep_body;
      int fft_body;
      rep_body = (int'(req_iter) << 12) | (int'(req_step) << 6) | int'(req_bdelay);
      fft_body = (4 << 24) | (int'(req_n_points) << 10) | (int'(req_radix) << 8) |
                 (int'(req_n_bu) << 7) | (int'(req_mode) << 6) | int'(req_fft_delay);
      if (req_port_mask[2]) begin
         push_word(1'b1, (6 << 24) | (int'(req_w_base) << 7) | (2 << 5), 4'h0, 4'h0, 1'b0);
         push_word(1'b1, (2 << 22) | rep_body, 4'h0, 4'h0, 1'b0);
      end
      if (req_port_mask[3]) begin
         push_word(1'b1, (6 << 24) | (int'(req_r_base) << 7) | (3 << 5), 4'h0, 4'h0, 1'b0);
         push_word(1'b1, (3 << 22) | rep_body, 4'h0, 4'h0, 1'b0);
      end
      if (req_port_mask[0]) push_word(1'b1, fft_body, 4'h0, 4'h0, 1'b0);
      if (req_port_mask[1]) push_word(1'b1, fft_body | (1 << 22), 4'h0, 4'h0, 1'b0);
      push_word(1'b0, 0, req_port_mask, req_port_mask & 4'h3, 1'b1);
   endfunction

   always @(posedge clk) begin
      word_t w;
      bit    was_idle;
      cyc++;
      exp_en = 1'b0; exp_instr = '0; exp_a0 = '0; exp_a1 = '0; exp_done = 1'b0;
      if (!rst_n) begin
         q.delete();
         err_pipe  = 1'b0;
         exp_err   = 1'b0;
         exp_ready = 1'b1;
      end else begin
         was_idle = (q.size() == 0);
         exp_err  = err_pipe;
         err_pipe = 1'b0;
         if (!was_idle && !hold) begin
            w = q.pop_front();
            exp_en = w.en; exp_instr = w.instr; exp_a0 = w.a0; exp_a1 = w.a1; exp_done = w.done;
         end
         if (was_idle && req_valid) begin
            if (req_port_mask != 4'h0 && legal_size(int'(req_n_points))) push_job();
            else err_pipe = 1'b1;
         end
         exp_ready = (q.size() == 0);
      end
   end

   always @(negedge clk) begin
      logic [42:0] got_v;
      logic [42:0] exp_v;
      got_v = {instr_en, instr, activate_0, activate_1, done, err, req_ready};
      if (!rst_n) exp_v = {1'b0, 27'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1};
      else exp_v = {exp_en, exp_instr, exp_a0, exp_a1, exp_done, exp_err, exp_ready};
      checks++;
      if (got_v !== exp_v) begin
         errors++;
         $display("FAIL outputs cyc=%0d got en=%0b instr=%07h a0=%h a1=%h done=%0b err=%0b rdy=%0b required en=%0b instr=%07h a0=%h a1=%h done=%0b err=%0b rdy=%0b",
                  cyc, got_v[42], got_v[41:15], got_v[14:11], got_v[10:7], got_v[6], got_v[5], got_v[4],
                  exp_v[42], exp_v[41:15], exp_v[14:11], exp_v[10:7], exp_v[6], exp_v[5], exp_v[4]);
      end
      if (instr_en) begin log_instr.push_back(instr); log_cyc.push_back(cyc); end
      if (done) begin done_cyc = cyc; act0_seen = activate_0; act1_seen = activate_1; end
      if (err) err_cyc = cyc;
   end

   task automatic check(string name, longint got, longint required);
      checks++;
      if (got !== required) begin
         errors++;
         $display("FAIL %s got=%0d required=%0d", name, got, required);
      end
   endtask

   task automatic set_fields(int n, int m);
      req_n_points = n[11:0]; req_radix = 2'd2; req_mode = 1'b0; req_n_bu = 1'b1;
      req_fft_delay = 6'd3; req_w_base = 16'd0; req_r_base = 16'd8; req_iter = 6'd4;
      req_step = 6'd1; req_bdelay = 6'd0; req_port_mask = m[3:0];
   endtask

   task automatic start_job();
      log_instr.delete(); log_cyc.delete();
      done_cyc = -1; err_cyc = -1;
      req_valid = 1'b1;
      @(posedge clk); #2;
      t_acc = cyc;
      req_valid = 1'b0;
   endtask

   task automatic wait_done(int bound);
      int n;
      n = 0;
      while (done_cyc < 0 && n < bound) begin @(posedge clk); #2; n++; end
      check("done_seen", done_cyc >= 0, 1);
      @(posedge clk); #2;
   endtask

   task automatic check_full_seq(string tag);
      check({tag, "_count"}, log_instr.size(), 6);
      for (int i = 0; i < 6; i++)
         if (i < log_instr.size()) check({tag, "_instr"}, log_instr[i], full_seq[i]);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk); #2;
      check("reset_ready", req_ready, 1);
      check("reset_instr_en", instr_en, 0);

      // Full job, all four ports
      set_fields(16, 4'hF);
      start_job();
      wait_done(20);
      check_full_seq("full");
      check("full_done_cyc", done_cyc, t_acc + 7);
      check("full_act0", act0_seen, 4'hF);
      check("full_act1", act1_seen, 4'h3);

      // Word AGU ports only
      set_fields(16, 4'b0011);
      start_job();
      wait_done(20);
      check("m3_count", log_instr.size(), 2);
      if (log_instr.size() == 2) begin
         check("m3_instr0", log_instr[0], 27'h4004283);
         check("m3_instr1", log_instr[1], 27'h4404283);
      end
      check("m3_done_cyc", done_cyc, t_acc + 3);
      check("m3_act0", act0_seen, 4'h3);
      check("m3_act1", act1_seen, 4'h3);

      // Rejected jobs
      set_fields(12, 4'hF);
      start_job(); repeat (3) begin @(posedge clk); #2; end
      check("bad12_err_cyc", err_cyc, t_acc + 1);
      check("bad12_no_instr", log_instr.size(), 0);
      check("bad12_ready", req_ready, 1);
      set_fields(256, 4'hF);
      start_job(); repeat (3) begin @(posedge clk); #2; end
      check("bad256_err_cyc", err_cyc, t_acc + 1);
      check("bad256_no_instr", log_instr.size(), 0);
      set_fields(16, 4'h0);
      start_job(); repeat (3) begin @(posedge clk); #2; end
      check("mask0_err_cyc", err_cyc, t_acc + 1);
      check("mask0_no_instr", log_instr.size(), 0);
      check("mask0_ready", req_ready, 1);

      // Hold for three cycles while REP_R is pending
      set_fields(16, 4'hF);
      start_job();
      repeat (3) @(posedge clk);
      #2 hold = 1'b1;
      repeat (3) @(posedge clk);
      #2 hold = 1'b0;
      wait_done(20);
      check_full_seq("hold");
      check("hold_done_cyc", done_cyc, t_acc + 10);

      // Reset during FFT_W
      set_fields(16, 4'hF);
      start_job();
      repeat (4) @(posedge clk);
      #7 rst_n = 1'b0;
      #1;
      check("rst_instr_en", instr_en, 0);
      check("rst_instr", instr, 0);
      @(posedge clk);
      #7 rst_n = 1'b1;
      repeat (10) begin @(posedge clk); #2; end
      check("rst_no_done", done_cyc, -1);
      check("rst_instr_count", log_instr.size(), 4);
      check("rst_ready", req_ready, 1);

      // Back-to-back request held high
      set_fields(16, 4'hF);
      log_instr.delete(); log_cyc.delete(); done_cyc = -1; err_cyc = -1;
      req_valid = 1'b1;
      @(posedge clk); #2;
      t_acc = cyc;
      repeat (8) @(posedge clk);
      #2 req_valid = 1'b0;
      check("b2b_first_done", done_cyc, t_acc + 7);
      repeat (12) begin @(posedge clk); #2; end
      check("b2b_count", log_instr.size(), 12);
      if (log_instr.size() > 6) check("b2b_second_first_cyc", log_cyc[6], t_acc + 9);
      check("b2b_second_done", done_cyc, t_acc + 15);

      // Randomized traffic against the model
      for (int i = 0; i < 800; i++) begin
         @(posedge clk); #2;
         req_valid = ($urandom_range(0, 2) == 0);
         case ($urandom_range(0, 9))
            0, 1, 2, 3, 4, 5: req_n_points = 12'd4 << $urandom_range(0, 5);
            6:       req_n_points = 12'd12;
            7:       req_n_points = 12'd256;
            8:       req_n_points = 12'd2;
            default: req_n_points = 12'($urandom_range(0, 4095));
         endcase
         req_radix     = 2'($urandom_range(0, 3));
         req_mode      = 1'($urandom_range(0, 1));
         req_n_bu      = 1'($urandom_range(0, 1));
         req_fft_delay = 6'($urandom_range(0, 63));
         req_w_base    = 16'($urandom_range(0, 65535));
         req_r_base    = 16'($urandom_range(0, 65535));
         req_iter      = 6'($urandom_range(0, 63));
         req_step      = 6'($urandom_range(0, 63));
         req_bdelay    = 6'($urandom_range(0, 63));
         req_port_mask = 4'($urandom_range(0, 15));
         hold          = ($urandom_range(0, 3) == 0);
      end
      req_valid = 1'b0;
      hold = 1'b0;
      repeat (20) @(posedge clk);
      #2;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
